// File: rtl/tl_ad_protocol_monitor_if.sv
// TileLink-UL/UH A/D channel bundle.
// Carries the A request channel (valid/ready, opcode, param, size, source, address, mask) and the
// D response channel (valid/ready, opcode, param, size, source, denied, corrupt).
// Modports:
//   master  - drives A, accepts D
//   slave   - accepts A, drives D
//   monitor - observes every signal, drives nothing
interface tl_ad_protocol_monitor_if #(
    parameter int unsigned SOURCE_W  = 7,
    parameter int unsigned ADDR_W    = 31,
    parameter int unsigned SIZE_W    = 3,
    parameter int unsigned BEAT_LOG2 = 3
) ();
    logic                      a_valid;
    logic                      a_ready;
    logic [2:0]                a_opcode;
    logic [2:0]                a_param;
    logic [SIZE_W-1:0]         a_size;
    logic [SOURCE_W-1:0]       a_source;
    logic [ADDR_W-1:0]         a_address;
    logic [2**BEAT_LOG2-1:0]   a_mask;

    logic                      d_valid;
    logic                      d_ready;
    logic [2:0]                d_opcode;
    logic [1:0]                d_param;
    logic [SIZE_W-1:0]         d_size;
    logic [SOURCE_W-1:0]       d_source;
    logic                      d_denied;
    logic                      d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt
    );

    modport monitor (
        input a_valid, a_ready, a_opcode, a_param, a_size, a_source, a_address, a_mask,
        input d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt
    );
endinterface

// File: rtl/tl_ad_protocol_monitor.sv
// Passive TileLink-UL/UH A/D protocol checker.
// Tracks in-flight requests per source, counts burst beats, and checks handshake stability,
// opcode/size/address legality, response matching and a response watchdog. The first
// violation is latched (code + source); every violation is counted.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   enable_i       0 suppresses all checks; tracking state keeps updating
//   tl             observed A/D channel bundle (monitor modport)
//   err_sticky_o   set on the first violation, cleared only by reset
//   err_code_o     code of the first violation
//   err_source_o   source associated with the first violation
//   err_count_o    violations seen, saturating at 16'hFFFF
//   inflight_o     number of sources currently in flight
module tl_ad_protocol_monitor #(
    parameter int unsigned SOURCE_W  = 7,
    parameter int unsigned ADDR_W    = 31,
    parameter int unsigned SIZE_W    = 3,
    parameter int unsigned BEAT_LOG2 = 3,
    parameter int unsigned MAX_SIZE  = 6,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    tl_ad_protocol_monitor_if.monitor tl,
    output logic                  err_sticky_o,
    output logic [3:0]            err_code_o,
    output logic [SOURCE_W-1:0]   err_source_o,
    output logic [15:0]           err_count_o,
    output logic [SOURCE_W:0]     inflight_o
);
    localparam int unsigned NSRC   = 2 ** SOURCE_W;
    localparam int unsigned MASK_W = 2 ** BEAT_LOG2;
    // Wide enough for the beat count of the largest encodable size.
    localparam int unsigned CNT_W  = 2 ** SIZE_W;
    localparam int unsigned INF_W  = SOURCE_W + 1;
    localparam int unsigned TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic [2:0]          op;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] src;
        logic [ADDR_W-1:0]   addr;
        logic [MASK_W-1:0]   mask;
    } a_beat_t;

    typedef struct packed {
        logic [2:0]          op;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] src;
        logic                denied;
        logic                corrupt;
    } d_beat_t;

    function automatic logic [CNT_W-1:0] beats_m1(input logic [SIZE_W-1:0] size,
                                                  input logic has_data);
        logic [CNT_W-1:0] r;
        r = '0;
        if (has_data && (size > SIZE_W'(BEAT_LOG2))) begin
            r = (CNT_W'(1) << (size - SIZE_W'(BEAT_LOG2))) - CNT_W'(1);
        end
        return r;
    endfunction

    // Put -> AccessAck, Get/Arith/Logic -> AccessAckData, Hint -> HintAck.
    function automatic logic [1:0] exp_dop(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            3'd2, 3'd3, 3'd4: r = 2'd1;
            3'd5:             r = 2'd2;
            default:          r = 2'd0;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    logic [CNT_W-1:0]    a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
    logic [2:0]          a_bop_q, d_bop_q;
    logic [SIZE_W-1:0]   a_bsize_q, d_bsize_q;
    logic [SOURCE_W-1:0] a_bsrc_q, d_bsrc_q;
    logic                a_stall_q, d_stall_q;
    a_beat_t             a_prev_q, a_cur;
    d_beat_t             d_prev_q, d_cur;
    logic [NSRC-1:0]     infl_q;
    logic [SIZE_W-1:0]   size_tbl_q [NSRC];
    logic [1:0]          dop_tbl_q  [NSRC];
    logic [INF_W-1:0]    cnt_q, cnt_d;
    logic                err_sticky_q, err_sticky_d;
    logic [3:0]          err_code_q, err_code_d;
    logic [SOURCE_W-1:0] err_source_q, err_source_d;
    logic [15:0]         err_count_q, err_count_d;

    // ---------------------------------------------------------------- decode
    logic a_fire, d_fire, a_first, d_first, d_last;
    logic clr, a_busy, set_new, misaligned, a_burst_bad, d_burst_bad, wd_hit;
    logic [ADDR_W-1:0] addr_lo_mask;
    logic [11:0] err_v;
    logic [3:0]  first_code, n_err;
    logic [SOURCE_W-1:0] first_src;
    logic [16:0] count_sum;

    assign a_cur = '{op: tl.a_opcode, param: tl.a_param, size: tl.a_size, src: tl.a_source,
                     addr: tl.a_address, mask: tl.a_mask};
    assign d_cur = '{op: tl.d_opcode, param: tl.d_param, size: tl.d_size, src: tl.d_source,
                     denied: tl.d_denied, corrupt: tl.d_corrupt};

    always_comb begin
        a_fire  = tl.a_valid & tl.a_ready;
        d_fire  = tl.d_valid & tl.d_ready;
        a_first = (a_cnt_q == '0);
        d_first = (d_cnt_q == '0);

        a_cnt_d = a_cnt_q;
        if (a_fire) a_cnt_d = a_first ? beats_m1(tl.a_size, ~tl.a_opcode[2]) : a_cnt_q - 1'b1;
        d_cnt_d = d_cnt_q;
        if (d_fire) d_cnt_d = d_first ? beats_m1(tl.d_size, tl.d_opcode == 3'd1) : d_cnt_q - 1'b1;
        d_last = d_first ? (beats_m1(tl.d_size, tl.d_opcode == 3'd1) == '0) : (d_cnt_q == 1);

        // Retiring and reissuing the same source in one cycle is legal: clear wins first.
        clr     = d_fire & d_last & infl_q[tl.d_source];
        a_busy  = infl_q[tl.a_source] & ~(clr & (tl.d_source == tl.a_source));
        set_new = a_fire & a_first & ~a_busy;
        cnt_d   = cnt_q + INF_W'(set_new) - INF_W'(clr);

        addr_lo_mask = ~({ADDR_W{1'b1}} << tl.a_size);
        misaligned   = |(tl.a_address & addr_lo_mask);
        a_burst_bad  = a_fire & ~a_first & ((tl.a_opcode != a_bop_q) | (tl.a_size != a_bsize_q) |
                                            (tl.a_source != a_bsrc_q));
        d_burst_bad  = d_fire & ~d_first & ((tl.d_opcode != d_bop_q) | (tl.d_size != d_bsize_q) |
                                            (tl.d_source != d_bsrc_q));
    end

    // Bit i flags error code i+1.
    always_comb begin
        err_v[0]  = a_stall_q & (~tl.a_valid | (a_cur != a_prev_q));
        err_v[1]  = d_stall_q & (~tl.d_valid | (d_cur != d_prev_q));
        err_v[2]  = a_fire & ((tl.a_opcode[2:1] == 2'b11) |
                              ((tl.a_param != 3'd0) & ((tl.a_opcode == 3'd0) |
                               (tl.a_opcode == 3'd1) | (tl.a_opcode == 3'd4))));
        err_v[3]  = a_fire & (misaligned | (tl.a_size > SIZE_W'(MAX_SIZE)));
        err_v[4]  = a_fire & (tl.a_mask == '0) & (tl.a_opcode != 3'd1);
        err_v[5]  = a_fire & a_first & a_busy;
        err_v[6]  = d_fire & d_first & ~infl_q[tl.d_source];
        err_v[7]  = d_fire & d_first & infl_q[tl.d_source] &
                    (tl.d_size != size_tbl_q[tl.d_source]);
        err_v[8]  = d_fire & ((d_first & infl_q[tl.d_source] &
                               (tl.d_opcode != {1'b0, dop_tbl_q[tl.d_source]})) |
                              (tl.d_param != 2'd0));
        err_v[9]  = a_burst_bad | d_burst_bad;
        err_v[10] = d_fire & (tl.d_opcode == 3'd1) & tl.d_denied & ~tl.d_corrupt;
        err_v[11] = wd_hit;
        if (!enable_i) err_v = '0;
    end

    always_comb begin
        first_code = 4'd0;
        n_err      = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (err_v[i]) first_code = 4'(i + 1);
            n_err = n_err + 4'(err_v[i]);
        end
        case (first_code)
            4'd1:                   first_src = a_prev_q.src;
            4'd2:                   first_src = d_prev_q.src;
            4'd3, 4'd4, 4'd5, 4'd6: first_src = tl.a_source;
            4'd10:                  first_src = a_burst_bad ? tl.a_source : tl.d_source;
            4'd12:                  first_src = '0;
            default:                first_src = tl.d_source;
        endcase

        count_sum    = {1'b0, err_count_q} + 17'(n_err);
        err_count_d  = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        err_sticky_d = err_sticky_q | (n_err != 4'd0);
        err_code_d   = err_code_q;
        err_source_d = err_source_q;
        if (!err_sticky_q && (n_err != 4'd0)) begin
            err_code_d   = first_code;
            err_source_d = first_src;
        end
    end

    // ---------------------------------------------------------------- watchdog
    if (TIMEOUT > 0) begin : g_wd
        logic [TO_W-1:0] wd_q, wd_d;
        logic            fired_q, fired_d;

        always_comb begin
            wd_d = wd_q;
            if (d_fire || (cnt_q == '0))     wd_d = '0;
            else if (wd_q != TO_W'(TIMEOUT)) wd_d = wd_q + 1'b1;
            wd_hit  = (wd_q == TO_W'(TIMEOUT)) & ~fired_q & ~d_fire & (cnt_q != '0);
            // One flag per expiry; re-armed by the next response.
            fired_d = d_fire ? 1'b0 : (fired_q | wd_hit);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wd_q    <= '0;
                fired_q <= 1'b0;
            end else begin
                wd_q    <= wd_d;
                fired_q <= fired_d;
            end
        end
    end else begin : g_no_wd
        assign wd_hit = 1'b0;
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_cnt_q   <= '0;
            d_cnt_q   <= '0;
            a_bop_q   <= '0;
            a_bsize_q <= '0;
            a_bsrc_q  <= '0;
            d_bop_q   <= '0;
            d_bsize_q <= '0;
            d_bsrc_q  <= '0;
            a_stall_q <= 1'b0;
            d_stall_q <= 1'b0;
            a_prev_q  <= '0;
            d_prev_q  <= '0;
            infl_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < NSRC; i++) begin
                size_tbl_q[i] <= '0;
                dop_tbl_q[i]  <= '0;
            end
            err_sticky_q <= 1'b0;
            err_code_q   <= '0;
            err_source_q <= '0;
            err_count_q  <= '0;
        end else begin
            a_cnt_q   <= a_cnt_d;
            d_cnt_q   <= d_cnt_d;
            a_stall_q <= tl.a_valid & ~tl.a_ready;
            d_stall_q <= tl.d_valid & ~tl.d_ready;
            a_prev_q  <= a_cur;
            d_prev_q  <= d_cur;
            if (a_fire && a_first) begin
                a_bop_q   <= tl.a_opcode;
                a_bsize_q <= tl.a_size;
                a_bsrc_q  <= tl.a_source;
            end
            if (d_fire && d_first) begin
                d_bop_q   <= tl.d_opcode;
                d_bsize_q <= tl.d_size;
                d_bsrc_q  <= tl.d_source;
            end
            // Clear before set so a same-cycle retire/reissue leaves the entry occupied.
            if (clr) infl_q[tl.d_source] <= 1'b0;
            if (a_fire && a_first) begin
                infl_q[tl.a_source]     <= 1'b1;
                size_tbl_q[tl.a_source] <= tl.a_size;
                dop_tbl_q[tl.a_source]  <= exp_dop(tl.a_opcode);
            end
            cnt_q        <= cnt_d;
            err_sticky_q <= err_sticky_d;
            err_code_q   <= err_code_d;
            err_source_q <= err_source_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_sticky_o = err_sticky_q;
    assign err_code_o   = err_code_q;
    assign err_source_o = err_source_q;
    assign err_count_o  = err_count_q;
    assign inflight_o   = cnt_q;
endmodule
